// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Multi-cycle sequencer for the 16-bit CPU. Each instruction is stepped
// through IDLE/FETCH/DECODE/EXEC/MEM/WB. The datapath controls are decoded
// combinationally from the state register, the IR opcode, MemReady and Zero.
// The shared instruction/data memory is handshaken through MemReady. A wait
// counter bounds every FETCH or MEM access to MEM_TIMEOUT cycles.
//
// Build option: define ILLEGAL_TRAP_EN to send illegal opcodes to HALT, where
// the FSM stays until Reset. When the macro is undefined, illegal opcodes
// behave as a NOP.
//
// Parameters
//   MEM_TIMEOUT  maximum number of MemReady wait cycles (1 .. 2^CNT_W-1)
//   CNT_W        width of the wait counter
//
// Ports
//   Clock     in   rising-edge clock
//   Reset     in   asynchronous, active-high reset
//   OPCODE    in   IR[15:12], stable from DECODE until the next FETCH
//   Zero      in   ALU zero flag
//   MemReady  in   memory access completes this cycle
//   IorD      out  0: PC addresses memory, 1: ALUOut addresses memory
//   IRWrite   out  load IR
//   PCWrite   out  load PC
//   PCSrc     out  0: PC+2, 1: branch target
//   RegDst    out  1: rd, 0: rt
//   AluSrc    out  1: immediate, 0: register
//   AluOp     out  00 add, 01 sub/compare, 10 R-funct, 11 I-arith
//   MemRead   out  memory read strobe
//   MemWrite  out  memory write strobe
//   MemToReg  out  write-back from MDR
//   RegWrite  out  register file write enable
//   MemErr    out  registered one-cycle pulse on a wait timeout
//   State     out  current state code, for debug
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] OPCODE,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       RegDst,
    output logic       AluSrc,
    output logic [1:0] AluOp,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       MemErr,
    output logic [2:0] State
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    // A wait cycle that finds the counter at this value is the
    // MEM_TIMEOUT-th consecutive cycle without MemReady.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [2:0]       nextState;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] waitCntNext;
    logic             waiting;
    logic             timeout;
    logic             isRType;
    logic             isIArith;
    logic             isLw;
    logic             isSw;
    logic             isBeq;

    always_comb begin
        isRType  = 1'b0;
        isIArith = 1'b0;
        isLw     = 1'b0;
        isSw     = 1'b0;
        isBeq    = 1'b0;
        case (OPCODE)
            4'b0000, 4'b0001, 4'b0010: isRType  = 1'b1;
            4'b1001, 4'b1010, 4'b1011: isIArith = 1'b1;
            4'b1100:                   isLw     = 1'b1;
            4'b1101:                   isSw     = 1'b1;
            4'b1111:                   isBeq    = 1'b1;
            default:                   ;
        endcase
    end

    assign waiting = ((State == S_FETCH) || (State == S_MEM)) && !MemReady;
    // A MemReady that arrives on the last allowed cycle wins over the timeout.
    assign timeout = waiting && (waitCnt == CNT_LAST);

    always_comb begin
        nextState = S_IDLE;
        case (State)
            S_IDLE:   nextState = S_FETCH;
            // A FETCH timeout simply retries. The PC is untouched because
            // PCWrite requires MemReady.
            S_FETCH:  nextState = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: nextState = S_EXEC;
            S_EXEC: begin
                if (isRType || isIArith)
                    nextState = S_WB;
                else if (isLw || isSw)
                    nextState = S_MEM;
                else if (isBeq)
                    nextState = S_FETCH;
                else
`ifdef ILLEGAL_TRAP_EN
                    nextState = S_HALT;
`else
                    nextState = S_FETCH;
`endif
            end
            S_MEM: begin
                if (MemReady)
                    nextState = isLw ? S_WB : S_FETCH;
                else if (timeout)
                    nextState = S_FETCH;
                else
                    nextState = S_MEM;
            end
            S_WB:     nextState = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_HALT:   nextState = S_HALT;
`else
            S_HALT:   nextState = S_IDLE;
`endif
            default:  nextState = S_IDLE;
        endcase
    end

    // Any state change or timeout restarts the count, so FETCH and MEM always
    // begin with a cleared counter.
    always_comb begin
        waitCntNext = waitCnt;
        if (timeout || (nextState != State))
            waitCntNext = '0;
        else if (waiting)
            waitCntNext = waitCnt + CNT_W'(1);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            State   <= S_IDLE;
            waitCnt <= '0;
            MemErr  <= 1'b0;
        end else begin
            State   <= nextState;
            waitCnt <= waitCntNext;
            MemErr  <= timeout;
        end
    end

    always_comb begin
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        RegDst   = 1'b0;
        AluSrc   = 1'b0;
        AluOp    = 2'b00;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        case (State)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                // The ALU precomputes the branch target while decoding.
                AluSrc = 1'b1;
            end
            S_EXEC: begin
                if (isRType) begin
                    AluOp = 2'b10;
                end else if (isIArith) begin
                    AluSrc = 1'b1;
                    AluOp  = 2'b11;
                end else if (isLw || isSw) begin
                    AluSrc = 1'b1;
                end else if (isBeq) begin
                    AluOp   = 2'b01;
                    PCSrc   = 1'b1;
                    PCWrite = Zero;
                end
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = isLw;
                MemWrite = isSw;
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = isRType;
                MemToReg = isLw;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//
// Directed bench for multicycle_ctrl_fsm. An instruction-level model expands
// each (opcode, fetch stalls, memory stalls, Zero) tuple into the cycle-by-
// cycle state and control word that the sequencer must produce. A single
// negedge process compares the DUT against that expectation. A log of DUT
// outputs is also checked against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

    localparam int TMO = 15;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2,
                           S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

    // Control word: {IorD, IRWrite, PCWrite, PCSrc, RegDst, AluSrc, AluOp,
    //                MemRead, MemWrite, MemToReg, RegWrite, MemErr}
    localparam logic [12:0] K_IORD   = 13'h1000;
    localparam logic [12:0] K_IRW    = 13'h0800;
    localparam logic [12:0] K_PCW    = 13'h0400;
    localparam logic [12:0] K_PCSRC  = 13'h0200;
    localparam logic [12:0] K_REGDST = 13'h0100;
    localparam logic [12:0] K_ALUSRC = 13'h0080;
    localparam logic [12:0] K_OP_SUB = 13'h0020;
    localparam logic [12:0] K_OP_R   = 13'h0040;
    localparam logic [12:0] K_OP_I   = 13'h0060;
    localparam logic [12:0] K_MEMRD  = 13'h0010;
    localparam logic [12:0] K_MEMWR  = 13'h0008;
    localparam logic [12:0] K_M2R    = 13'h0004;
    localparam logic [12:0] K_REGW   = 13'h0002;
    localparam logic [12:0] K_MEMERR = 13'h0001;

    localparam int CL_R = 0, CL_I = 1, CL_LW = 2, CL_SW = 3, CL_BEQ = 4, CL_ILL = 5;

    logic       Clock, Reset, Zero, MemReady;
    logic [3:0] OPCODE;
    logic       IorD, IRWrite, PCWrite, PCSrc, RegDst, AluSrc;
    logic [1:0] AluOp;
    logic       MemRead, MemWrite, MemToReg, RegWrite, MemErr;
    logic [2:0] State;
    logic [12:0] dutCtl;

    int          nTests = 0;
    int          nFail  = 0;
    logic        expValid = 1'b0;
    logic [2:0]  expState;
    logic [12:0] expCtl;
    bit          errPending = 1'b0;
    logic [15:0] logQ[$];

    typedef struct {
        logic [3:0] op;
        int         f;
        int         m;
        logic       z;
    } vec_t;
    vec_t vecs [0:8];

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut (
        .Clock(Clock), .Reset(Reset), .OPCODE(OPCODE), .Zero(Zero),
        .MemReady(MemReady), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .RegDst(RegDst), .AluSrc(AluSrc), .AluOp(AluOp),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .MemErr(MemErr), .State(State)
    );

    assign dutCtl = {IorD, IRWrite, PCWrite, PCSrc, RegDst, AluSrc, AluOp,
                     MemRead, MemWrite, MemToReg, RegWrite, MemErr};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Per-cycle comparison against the model.
    always @(negedge Clock) begin
        if (expValid) begin
            nTests++;
            if (State !== expState || dutCtl !== expCtl) begin
                nFail++;
                $display("FAIL cycle t=%0t: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                         $time, State, dutCtl, expState, expCtl);
            end
        end
    end

    always @(negedge Clock) logQ.push_back({State, dutCtl});

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        nTests++;
        if (act != req) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int opClass(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010: return CL_R;
            4'b1001, 4'b1010, 4'b1011: return CL_I;
            4'b1100:                   return CL_LW;
            4'b1101:                   return CL_SW;
            4'b1111:                   return CL_BEQ;
            default:                   return CL_ILL;
        endcase
    endfunction

    function automatic int countBit(input int b);
        int n = 0;
        foreach (logQ[i]) if (logQ[i][b]) n++;
        return n;
    endfunction

    function automatic int stAt(input int i);
        return int'(logQ[i][15:13]);
    endfunction

    // One clock cycle: drive inputs, publish the expectation, advance.
    task automatic cyc(input logic [3:0] op, input logic rdy, input logic z,
                       input logic [2:0] st, input logic [12:0] ctl, input bit to);
        OPCODE   = op;
        MemReady = rdy;
        Zero     = z;
        expState = st;
        expCtl   = ctl | (errPending ? K_MEMERR : 13'h0);
        expValid = 1'b1;
        errPending = to;
        @(posedge Clock);
        #1;
    endtask

    task automatic doReset();
        expValid   = 1'b0;
        errPending = 1'b0;
        Reset      = 1'b1;
        MemReady   = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset-state", int'(State), 0);
        chk("reset-ctl", int'(dutCtl), 0);
        Reset = 1'b0;
        cyc(4'b0000, 1'b0, 1'b0, S_IDLE, 13'h0, 1'b0);
    endtask

    task automatic doFetch(input logic [3:0] op, input int stall, input logic z);
        int k = 0;
        bit to;
        for (int i = 0; i < stall; i++) begin
            k++;
            to = (k == TMO);
            cyc(op, 1'b0, z, S_FETCH, K_MEMRD, to);
            if (to) k = 0;
        end
        cyc(op, 1'b1, z, S_FETCH, K_MEMRD | K_IRW | K_PCW, 1'b0);
    endtask

    task automatic runInstr(input logic [3:0] op, input int fStall, input int mStall,
                            input logic z);
        int          c = opClass(op);
        int          k = 0;
        bit          to;
        logic [12:0] memCtl;
        doFetch(op, fStall, z);
        cyc(op, 1'b0, z, S_DEC, K_ALUSRC, 1'b0);
        case (c)
            CL_R: begin
                cyc(op, 1'b0, z, S_EXEC, K_OP_R, 1'b0);
                cyc(op, 1'b0, z, S_WB, K_REGW | K_REGDST, 1'b0);
            end
            CL_I: begin
                cyc(op, 1'b0, z, S_EXEC, K_ALUSRC | K_OP_I, 1'b0);
                cyc(op, 1'b0, z, S_WB, K_REGW, 1'b0);
            end
            CL_LW, CL_SW: begin
                memCtl = K_IORD | ((c == CL_LW) ? K_MEMRD : K_MEMWR);
                cyc(op, 1'b0, z, S_EXEC, K_ALUSRC, 1'b0);
                for (int i = 0; i < mStall; i++) begin
                    k++;
                    to = (k == TMO);
                    cyc(op, 1'b0, z, S_MEM, memCtl, to);
                    if (to) return;
                end
                cyc(op, 1'b1, z, S_MEM, memCtl, 1'b0);
                if (c == CL_LW) cyc(op, 1'b0, z, S_WB, K_REGW | K_M2R, 1'b0);
            end
            CL_BEQ: begin
                cyc(op, 1'b0, z, S_EXEC, K_OP_SUB | K_PCSRC | (z ? K_PCW : 13'h0), 1'b0);
            end
            default: begin
                cyc(op, 1'b0, z, S_EXEC, 13'h0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 4; i++) cyc(op, 1'b1, z, S_HALT, 13'h0, 1'b0);
`endif
            end
        endcase
    endtask

    initial begin
        Reset = 1'b1; OPCODE = 4'b0000; Zero = 1'b0; MemReady = 1'b0;
        vecs[0] = '{op: 4'b0000, f: 0,  m: 0,  z: 1'b0};
        vecs[1] = '{op: 4'b0010, f: 2,  m: 0,  z: 1'b0};
        vecs[2] = '{op: 4'b1001, f: 0,  m: 0,  z: 1'b1};
        vecs[3] = '{op: 4'b1011, f: 1,  m: 0,  z: 1'b0};
        vecs[4] = '{op: 4'b1101, f: 0,  m: 0,  z: 1'b0};
        vecs[5] = '{op: 4'b1101, f: 0,  m: 15, z: 1'b0};
        vecs[6] = '{op: 4'b1100, f: 0,  m: 14, z: 1'b0};
        vecs[7] = '{op: 4'b1111, f: 3,  m: 0,  z: 1'b1};
        vecs[8] = '{op: 4'b0001, f: 31, m: 0,  z: 1'b0};

        doReset();

        // ADD: states 1,2,3,5 then back to 1.
        logQ.delete();
        runInstr(4'b0001, 0, 0, 1'b0);
        chk("add-len", logQ.size(), 4);
        chk("add-states", (stAt(0) << 9) | (stAt(1) << 6) | (stAt(2) << 3) | stAt(3), 'o1235);
        chk("add-regwrite-count", countBit(1), 1);
        chk("add-wb-regdst", int'(logQ[3][8]), 1);
        chk("add-exec-aluop", int'(logQ[2][6:5]), 2);
        chk("add-return-fetch", int'(State), 1);

        // LW with MemReady low for 3 cycles in MEM.
        logQ.delete();
        runInstr(4'b1100, 0, 3, 1'b0);
        begin
            int n = 0;
            foreach (logQ[i]) if (logQ[i][15:13] == 3'd4 && logQ[i][4]) n++;
            chk("lw-memread-cycles", n, 4);
        end
        chk("lw-wb-state", stAt(logQ.size() - 1), 5);
        chk("lw-wb-m2r-regw", int'(logQ[logQ.size() - 1][2:1]), 3);

        // BEQ taken and not taken.
        logQ.delete();
        runInstr(4'b1111, 0, 0, 1'b1);
        chk("beq1-len", logQ.size(), 3);
        chk("beq1-pcw-pcsrc", int'(logQ[2][10:9]), 3);
        chk("beq1-return", int'(State), 1);
        logQ.delete();
        runInstr(4'b1111, 0, 0, 1'b0);
        chk("beq0-pcw", int'(logQ[2][10]), 0);
        chk("beq0-return", int'(State), 1);

        // FETCH timeout after 15 idle cycles, then MemReady on cycle 15.
        logQ.delete();
        runInstr(4'b0001, 15, 0, 1'b0);
        chk("fetch15-memerr", countBit(0), 1);
        chk("fetch15-irwrite", countBit(11), 1);
        logQ.delete();
        runInstr(4'b0001, 14, 0, 1'b0);
        chk("fetch14-memerr", countBit(0), 0);

        // MEM timeout on LW aborts with no register write.
        logQ.delete();
        runInstr(4'b1100, 0, 20, 1'b0);
        chk("lw-abort-regwrite", countBit(1), 0);
        chk("lw-abort-fetch", int'(State), 1);

        foreach (vecs[i]) runInstr(vecs[i].op, vecs[i].f, vecs[i].m, vecs[i].z);

        // Reset in the middle of a SW memory wait.
        doFetch(4'b1101, 0, 1'b0);
        cyc(4'b1101, 1'b0, 1'b0, S_DEC, K_ALUSRC, 1'b0);
        cyc(4'b1101, 1'b0, 1'b0, S_EXEC, K_ALUSRC, 1'b0);
        cyc(4'b1101, 1'b0, 1'b0, S_MEM, K_IORD | K_MEMWR, 1'b0);
        expValid = 1'b0;
        #1;
        chk("sw-pre-reset-memwrite", int'(MemWrite), 1);
        Reset = 1'b1;
        #1;
        chk("sw-reset-state", int'(State), 0);
        chk("sw-reset-memwrite", int'(MemWrite), 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        errPending = 1'b0;
        cyc(4'b1101, 1'b0, 1'b0, S_IDLE, 13'h0, 1'b0);
        chk("sw-reset-fetch", int'(State), 1);
        runInstr(4'b0001, 14, 0, 1'b0);

        // Illegal opcode 0111.
        logQ.delete();
        runInstr(4'b0111, 0, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        chk("ill-len", logQ.size(), 7);
        chk("ill-halt-state", stAt(6), 6);
        chk("ill-halt-held", int'(State), 6);
        chk("ill-no-writes", countBit(1) + countBit(3), 0);
        doReset();
        chk("ill-recover", int'(State), 1);
`else
        chk("ill-len", logQ.size(), 3);
        chk("ill-states", (stAt(0) << 6) | (stAt(1) << 3) | stAt(2), 'o123);
        chk("ill-no-writes", countBit(1) + countBit(3), 0);
        chk("ill-return", int'(State), 1);
`endif

        expValid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
